// File: rtl/lifo_frame_reader.sv
// Read-side controller for the 16-deep LIFO: pops a frame of bytes and streams them
// over a valid/ready interface, marking the final byte and aborting on a stalled stack.
`timescale 1ns/1ps
module lifo_frame_reader #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 5,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [LEN_W-1:0]  frame_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              lifo_read_en,
    input  logic              lifo_empty,
    input  logic [DATA_W-1:0] lifo_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [LEN_W-1:0]  popped_cnt
);

    localparam int unsigned Depth = 16;
    localparam int unsigned TmoW  = $clog2(TIMEOUT + 1);

    localparam logic [LEN_W-1:0] MaxLen   = LEN_W'(Depth);
    localparam logic [TmoW-1:0]  TmoLimit = TmoW'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StPop,
        StWait,
        StSend,
        StFin
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W-1:0]    popped_q, popped_d;
    logic [TmoW-1:0]     tmo_q, tmo_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                m_valid_q, m_valid_d;
    logic                m_last_q, m_last_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                rd_en;
    logic [LEN_W-1:0]    popped_inc;
    logic [TmoW-1:0]     tmo_inc;

    assign popped_inc = popped_q + 1'b1;
    // Saturating increment so the counter can never wrap back below the limit.
    assign tmo_inc    = (tmo_q == TmoLimit) ? tmo_q : tmo_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        popped_d  = popped_q;
        tmo_d     = tmo_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        err_d     = 1'b0;
        rd_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    popped_d = '0;
                    tmo_d    = '0;
                    if (frame_len == '0) begin
                        len_d   = '0;
                        state_d = StFin;
                    end else begin
                        len_d   = (frame_len > MaxLen) ? MaxLen : frame_len;
                        state_d = StPop;
                    end
                end
            end

            StPop: begin
                if (!lifo_empty) begin
                    rd_en   = 1'b1;
                    tmo_d   = '0;
                    state_d = StWait;
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TmoLimit) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end

            // LIFO output is valid during this cycle, one cycle after the pop.
            StWait: begin
                m_data_d  = lifo_data;
                m_valid_d = 1'b1;
                m_last_d  = (popped_q == (len_q - 1'b1));
                state_d   = StSend;
            end

            StSend: begin
                if (m_ready) begin
                    m_valid_d = 1'b0;
                    m_last_d  = 1'b0;
                    popped_d  = popped_inc;
                    state_d   = (popped_inc == len_q) ? StFin : StPop;
                end
            end

            StFin: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        done_d = (state_d == StFin);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= StIdle;
            len_q     <= '0;
            popped_q  <= '0;
            tmo_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            popped_q  <= popped_d;
            tmo_q     <= tmo_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = done_q;
    assign err          = err_q;
    assign lifo_read_en = rd_en;
    assign m_valid      = m_valid_q;
    assign m_data       = m_data_q;
    assign m_last       = m_last_q;
    assign popped_cnt   = popped_q;

endmodule

// File: tb/tb_lifo_frame_reader.sv
// Directed bench for lifo_frame_reader with a behavioural 16-deep LIFO (one-cycle read latency).
`timescale 1ns/1ps
module tb_lifo_frame_reader;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [4:0] frame_len;
    logic       busy;
    logic       done;
    logic       err;
    logic       lifo_read_en;
    logic       lifo_empty;
    logic [7:0] lifo_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic [4:0] popped_cnt;

    logic       push_en;
    logic [7:0] push_data;

    int n_tests  = 0;
    int n_failed = 0;

    lifo_frame_reader #(
        .DATA_W (8),
        .LEN_W  (5),
        .TIMEOUT(16)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .frame_len   (frame_len),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .lifo_read_en(lifo_read_en),
        .lifo_empty  (lifo_empty),
        .lifo_data   (lifo_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .popped_cnt  (popped_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural LIFO: pop data appears on lifo_data the cycle after the pop.
    logic [7:0] mem [16];
    int         sp = 0;
    assign lifo_empty = (sp == 0);

    always @(posedge clock) begin
        if (push_en && sp < 16) begin
            mem[sp] <= push_data;
            sp      <= sp + 1;
        end else if (lifo_read_en && sp != 0) begin
            lifo_data <= mem[sp-1];
            sp        <= sp - 1;
        end
    end

    // Monitors
    logic [7:0] got_data [64];
    logic       got_last [64];
    int n_got = 0, n_done = 0, n_err = 0, n_rd = 0, n_valid = 0, n_under = 0;

    always @(posedge clock) begin
        if (m_valid && m_ready && n_got < 64) begin
            got_data[n_got] <= m_data;
            got_last[n_got] <= m_last;
            n_got           <= n_got + 1;
        end
        if (done)                       n_done  <= n_done + 1;
        if (err)                        n_err   <= n_err + 1;
        if (lifo_read_en)               n_rd    <= n_rd + 1;
        if (m_valid)                    n_valid <= n_valid + 1;
        if (lifo_read_en && lifo_empty) n_under <= n_under + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_failed++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        push_en   = 1'b1;
        push_data = b;
        tick();
        push_en   = 1'b0;
    endtask

    task automatic start_frame(input logic [4:0] len);
        start     = 1'b1;
        frame_len = len;
        tick();
        start     = 1'b0;
    endtask

    // Waits for done (want_err=0) or err (want_err=1); ticks = cycles waited.
    task automatic wait_pulse(input bit want_err, input int max, output int ticks);
        ticks = 0;
        while (!(want_err ? err : done) && ticks < max) begin
            tick();
            ticks++;
        end
    endtask

    int base, d0, e0, r0, v0, t;

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        frame_len = '0;
        m_ready   = 1'b0;
        push_en   = 1'b0;
        push_data = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", m_valid, 0);
        check("rst_last", m_last, 0);
        check("rst_data", m_data, 0);
        check("rst_popped", popped_cnt, 0);
        check("rst_rd_en", lifo_read_en, 0);
        resetn = 1'b1;
        tick();

        // Basic 3-byte frame, consumer always ready
        push(8'h11);
        push(8'h22);
        push(8'h33);
        base = n_got; d0 = n_done;
        m_ready = 1'b1;
        start_frame(5'd3);
        check("t1_busy", busy, 1);
        check("t1_first_pop", lifo_read_en, 1);
        wait_pulse(0, 40, t);
        check("t1_done_seen", done, 1);
        check("t1_latency", t, 9);
        tick();
        check("t1_n_bytes", n_got - base, 3);
        check("t1_b0", got_data[base], 8'h33);
        check("t1_b1", got_data[base+1], 8'h22);
        check("t1_b2", got_data[base+2], 8'h11);
        check("t1_l0", got_last[base], 0);
        check("t1_l1", got_last[base+1], 0);
        check("t1_l2", got_last[base+2], 1);
        check("t1_done_cnt", n_done - d0, 1);
        check("t1_popped", popped_cnt, 3);
        check("t1_empty", lifo_empty, 1);
        check("t1_idle", busy, 0);

        // Backpressure on first byte
        push(8'hA1);
        push(8'hA2);
        base = n_got;
        m_ready = 1'b0;
        start_frame(5'd2);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", m_valid, 1);
            check("t2_hold_data", m_data, 8'hA2);
            check("t2_hold_last", m_last, 0);
            check("t2_hold_no_pop", lifo_read_en, 0);
            tick();
        end
        m_ready = 1'b1;
        wait_pulse(0, 40, t);
        check("t2_done_seen", done, 1);
        tick();
        check("t2_n_bytes", n_got - base, 2);
        check("t2_b0", got_data[base], 8'hA2);
        check("t2_b1", got_data[base+1], 8'hA1);
        check("t2_l0", got_last[base], 0);
        check("t2_l1", got_last[base+1], 1);
        check("t2_popped", popped_cnt, 2);

        // Underrun: only one entry for a 2-byte frame
        push(8'h5C);
        base = n_got; d0 = n_done; e0 = n_err;
        start_frame(5'd2);
        wait_pulse(1, 60, t);
        check("t3_err_seen", err, 1);
        check("t3_err_latency", t, 19);
        check("t3_busy_drop", busy, 0);
        check("t3_popped", popped_cnt, 1);
        tick();
        check("t3_err_pulse", err, 0);
        check("t3_err_cnt", n_err - e0, 1);
        check("t3_no_done", n_done - d0, 0);
        check("t3_n_bytes", n_got - base, 1);
        check("t3_b0", got_data[base], 8'h5C);
        check("t3_l0", got_last[base], 0);

        // Zero-length frame
        r0 = n_rd; v0 = n_valid; d0 = n_done;
        start_frame(5'd0);
        check("t4_done", done, 1);
        check("t4_busy", busy, 1);
        check("t4_no_pop", lifo_read_en, 0);
        tick();
        check("t4_done_off", done, 0);
        check("t4_idle", busy, 0);
        check("t4_rd_cnt", n_rd - r0, 0);
        check("t4_valid_cnt", n_valid - v0, 0);
        check("t4_done_cnt", n_done - d0, 1);

        // Full stack, start pulsed mid-frame
        for (int i = 0; i < 16; i++) push(8'(i));
        base = n_got; d0 = n_done;
        start_frame(5'd16);
        for (int i = 0; i < 5; i++) tick();
        start_frame(5'd3);
        wait_pulse(0, 100, t);
        check("t5_done_seen", done, 1);
        check("t5_latency", t, 42);
        tick();
        check("t5_n_bytes", n_got - base, 16);
        for (int i = 0; i < 16; i++) begin
            check("t5_byte", got_data[base+i], 8'(15 - i));
            check("t5_last", got_last[base+i], (i == 15) ? 1 : 0);
        end
        check("t5_popped", popped_cnt, 16);
        check("t5_done_cnt", n_done - d0, 1);
        check("t5_empty", lifo_empty, 1);

        // Oversized length clamps to 16
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        base = n_got; d0 = n_done; e0 = n_err;
        start_frame(5'd31);
        wait_pulse(0, 100, t);
        check("t6_done_seen", done, 1);
        tick();
        check("t6_n_bytes", n_got - base, 16);
        check("t6_last_byte", got_data[base+15], 8'h20);
        check("t6_last_flag", got_last[base+15], 1);
        check("t6_popped", popped_cnt, 16);
        check("t6_no_err", n_err - e0, 0);

        // Reset during SEND
        push(8'h77);
        push(8'h88);
        m_ready = 1'b0;
        start_frame(5'd2);
        tick();
        tick();
        check("t7_in_send", m_valid, 1);
        d0 = n_done; e0 = n_err;
        resetn = 1'b0;
        tick();
        check("t7_valid", m_valid, 0);
        check("t7_busy", busy, 0);
        check("t7_data", m_data, 0);
        check("t7_popped", popped_cnt, 0);
        resetn = 1'b1;
        tick();
        check("t7_no_done", n_done - d0, 0);
        check("t7_no_err", n_err - e0, 0);
        base = n_got;
        m_ready = 1'b1;
        start_frame(5'd1);
        wait_pulse(0, 40, t);
        check("t7_done_seen", done, 1);
        tick();
        check("t7_n_bytes", n_got - base, 1);
        check("t7_b0", got_data[base], 8'h77);
        check("t7_l0", got_last[base], 1);
        check("t7_popped2", popped_cnt, 1);

        check("no_underflow", n_under, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
